// File: rtl/load_ext_pipe.sv
// Two-stage valid/ready pipeline that picks the addressed byte/half/word lane of a
// memory read word and zero- or sign-extends it for writeback, flagging bad beats.
module load_ext_pipe #(
  parameter  int DATA_W = 32,
  parameter  int TAG_W  = 5,
  parameter  int CNT_W  = 8,
  localparam int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [2:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [2:0] {
    MODE_WORD   = 3'd0,
    MODE_HALF_U = 3'd1,
    MODE_HALF_S = 3'd2,
    MODE_BYTE_U = 3'd3,
    MODE_BYTE_S = 3'd4
  } mode_e;

  // Stage 1: shifted lane plus decoded error
  logic              s1_v_q,    s1_v_d;
  logic [DATA_W-1:0] s1_lane_q, s1_lane_d;
  logic [2:0]        s1_mode_q, s1_mode_d;
  logic              s1_err_q,  s1_err_d;
  logic [TAG_W-1:0]  s1_tag_q,  s1_tag_d;

  // Stage 2: extended result, drives the output port directly
  logic              s2_v_q,    s2_v_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [TAG_W-1:0]  s2_tag_q,  s2_tag_d;
  logic              s2_err_q,  s2_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              s2_take;
  logic              in_fire;
  logic              s1_fire;
  logic              out_fire;
  logic              in_err;
  logic [DATA_W-1:0] ext_data;

  assign s2_take  = !s2_v_q || out_ready;
  assign in_ready = !s1_v_q || s2_take;
  assign in_fire  = in_valid && in_ready;
  assign s1_fire  = s1_v_q && s2_take;
  // A beat killed by flush in the same cycle is not treated as delivered.
  assign out_fire = s2_v_q && out_ready && !flush;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    in_err = 1'b0;
    case (in_mode)
      MODE_WORD:                in_err = (in_off != '0);
      MODE_HALF_U, MODE_HALF_S: in_err = in_off[0];
      MODE_BYTE_U, MODE_BYTE_S: in_err = 1'b0;
      default:                  in_err = 1'b1;
    endcase
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_lane_d = s1_lane_q;
    s1_mode_d = s1_mode_q;
    s1_err_d  = s1_err_q;
    s1_tag_d  = s1_tag_q;
    if (in_ready) s1_v_d = in_valid;
    if (in_fire) begin
      s1_lane_d = in_data >> {in_off, 3'b000};
      s1_mode_d = in_mode;
      s1_err_d  = in_err;
      s1_tag_d  = in_tag;
    end
    if (flush) s1_v_d = 1'b0;
  end

  always_comb begin
    ext_data = '0;
    case (s1_mode_q)
      MODE_WORD:   ext_data = s1_lane_q;
      MODE_HALF_U: ext_data = {{(DATA_W-16){1'b0}}, s1_lane_q[15:0]};
      MODE_HALF_S: ext_data = {{(DATA_W-16){s1_lane_q[15]}}, s1_lane_q[15:0]};
      MODE_BYTE_U: ext_data = {{(DATA_W-8){1'b0}}, s1_lane_q[7:0]};
      MODE_BYTE_S: ext_data = {{(DATA_W-8){s1_lane_q[7]}}, s1_lane_q[7:0]};
      default:     ext_data = '0;
    endcase
    if (s1_err_q) ext_data = '0;
  end

  always_comb begin
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_tag_d  = s2_tag_q;
    s2_err_d  = s2_err_q;
    if (s2_take) s2_v_d = s1_v_q;
    // Payload only changes when a real beat moves up, keeping held outputs stable.
    if (s1_fire) begin
      s2_data_d = ext_data;
      s2_tag_d  = s1_tag_q;
      s2_err_d  = s1_err_q;
    end
    if (flush) s2_v_d = 1'b0;
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_fire && s2_err_q && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  // NOTE: payload registers are reset along with the valids because the output
  // port must read as zero immediately on reset, not just be marked invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q    <= 1'b0;
      s1_lane_q <= '0;
      s1_mode_q <= '0;
      s1_err_q  <= 1'b0;
      s1_tag_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_tag_q  <= '0;
      s2_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_lane_q <= s1_lane_d;
      s1_mode_q <= s1_mode_d;
      s1_err_q  <= s1_err_d;
      s1_tag_q  <= s1_tag_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_tag_q  <= s2_tag_d;
      s2_err_q  <= s2_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;
  assign out_err   = s2_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_load_ext_pipe.sv
// Directed bench for load_ext_pipe: extension cases, error flagging, backpressure,
// flush, asynchronous reset and counter saturation, all against hand-derived values.
module tb_load_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_off;
  logic [2:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  load_ext_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_off    (in_off),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat with out_ready high: accepted at the first edge, visible after the second.
  task automatic send_one(input string name, input logic [2:0] mode, input logic [31:0] data,
                          input logic [1:0] off, input logic [4:0] tag,
                          input logic [31:0] exp_data, input logic exp_err);
    in_valid  = 1'b1;
    in_mode   = mode;
    in_data   = data;
    in_off    = off;
    in_tag    = tag;
    out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check({name, "_lat1"}, out_valid, 1'b0);
    tick();
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_data"}, out_data, exp_data);
    check({name, "_tag"}, out_tag, tag);
    check({name, "_err"}, out_err, exp_err);
    if (exp_err) exp_cnt++;
    tick();
    check({name, "_drained"}, out_valid, 1'b0);
    check({name, "_cnt"}, err_cnt, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int in_idx, out_idx, acc, got;
    logic in_hs;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_off = '0;
    in_mode = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 32'h0);
    check("rst_cnt", err_cnt, 8'h0);
    reset = 1'b0;
    tick();

    // Lane extension cases
    send_one("byte_s",  3'd4, 32'h12F4_5678, 2'd2, 5'd1, 32'hFFFF_FFF4, 1'b0);
    send_one("half_u",  3'd1, 32'h8001_7FFF, 2'd2, 5'd2, 32'h0000_8001, 1'b0);
    send_one("half_s",  3'd2, 32'h8001_7FFF, 2'd2, 5'd3, 32'hFFFF_8001, 1'b0);
    send_one("byte_u",  3'd3, 32'h12F4_5678, 2'd3, 5'd4, 32'h0000_0012, 1'b0);
    send_one("half_s0", 3'd2, 32'h8001_7FFF, 2'd0, 5'd5, 32'h0000_7FFF, 1'b0);
    send_one("word",    3'd0, 32'hCAFE_F00D, 2'd0, 5'd6, 32'hCAFE_F00D, 1'b0);

    // Error beats: misaligned half, illegal mode, misaligned word
    send_one("err_half", 3'd2, 32'h8001_7FFF, 2'd1, 5'd7, 32'h0, 1'b1);
    send_one("err_mode", 3'd6, 32'h1234_5678, 2'd0, 5'd8, 32'h0, 1'b1);
    send_one("err_word", 3'd0, 32'h1234_5678, 2'd2, 5'd9, 32'h0, 1'b1);

    // Backpressure stream of six WORD beats, consumer stalls in cycles 3-5
    in_idx = 0; out_idx = 0;
    for (int c = 0; c < 40 && out_idx < 6; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (in_idx < 6);
      in_mode   = 3'd0;
      in_off    = 2'd0;
      in_data   = 32'hA500_0000 + 32'(in_idx);
      in_tag    = 5'(10 + in_idx);
      #1;
      if (c == 4) begin
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_held_tag", out_tag, 5'd11);
      end
      in_hs = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check($sformatf("bp_data%0d", out_idx), out_data, 32'hA500_0000 + 32'(out_idx));
        check($sformatf("bp_tag%0d", out_idx), out_tag, 5'(10 + out_idx));
        out_idx++;
      end
      tick();
      if (in_hs) in_idx++;
    end
    in_valid = 1'b0;
    check("bp_count", out_idx, 6);
    tick();

    // Flush with both stages full and a third beat presented; erroneous beats never counted
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 3'd7; in_off = 2'd0; in_data = 32'h1111_1111; in_tag = 5'd20;
    tick();
    in_tag = 5'd21;
    tick();
    check("fl_full", out_valid, 1'b1);
    in_tag = 5'd22;
    flush  = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_valid_next", out_valid, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("fl_quiet%0d", c), out_valid, 1'b0);
    end
    check("fl_cnt", err_cnt, exp_cnt);

    // Asynchronous reset while a beat is held at the output
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 3'd0; in_off = 2'd0; in_data = 32'hDEAD_BEEF; in_tag = 5'd7;
    tick();
    in_valid = 1'b0;
    tick();
    check("ar_before", out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", out_valid, 1'b0);
    check("ar_data", out_data, 32'h0);
    check("ar_tag", out_tag, 5'd0);
    check("ar_err", out_err, 1'b0);
    check("ar_cnt", err_cnt, 8'h0);
    exp_cnt = 0;
    tick();
    reset = 1'b0;
    tick();

    // 256 illegal-mode beats: counter must stop at 255
    out_ready = 1'b1;
    acc = 0; got = 0;
    for (int c = 0; c < 600 && got < 256; c++) begin
      in_valid = (acc < 256);
      in_mode  = 3'd5;
      in_data  = 32'h5A5A_5A5A;
      in_tag   = 5'(acc);
      #1;
      in_hs = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (got == 255) check("sat_cnt_255", err_cnt, 8'd255);
        got++;
      end
      tick();
      if (in_hs) acc++;
    end
    in_valid = 1'b0;
    tick();
    check("sat_delivered", got, 256);
    check("sat_cnt_final", err_cnt, 8'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
